// File: rtl/qsys_hex_display_pio.sv
// Avalon-MM seven-segment output PIO with atomic set/clear writes and a per-digit
// hardware blink engine driven by a programmable half-period divider.
module qsys_hex_display_pio #(
  parameter int          NUM_DIGITS      = 4,
  parameter int          DIGIT_WIDTH     = 7,
  parameter logic [31:0] RESET_VALUE     = 32'hFFFF_FFFF,
  parameter logic [31:0] BLINK_DIV_RESET = 32'd25_000_000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [2:0]                        address,
  input  logic                              chipselect,
  input  logic                              write_n,
  input  logic [31:0]                       writedata,
  output logic [31:0]                       readdata,
  output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] out_port
);

  localparam int W = NUM_DIGITS * DIGIT_WIDTH;
  localparam logic [W-1:0] RST_DATA = RESET_VALUE[W-1:0];

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_DIV   = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_SET   = 3'd4;
  localparam logic [2:0] A_CLEAR = 3'd5;

  logic [W-1:0]          data_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [31:0]           div_q;
  logic [31:0]           cnt_q;
  logic                  phase_q;
  logic                  wr;
  logic                  unused_wdata;

  assign wr = chipselect && !write_n;
  // Only the low W bits of writedata reach DATA; the rest are deliberately dropped.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RST_DATA;
      mask_q <= '0;
      div_q  <= BLINK_DIV_RESET;
    end else if (wr) begin
      case (address)
        A_DATA:  data_q <= writedata[W-1:0];
        A_MASK:  mask_q <= writedata[NUM_DIGITS-1:0];
        A_DIV:   div_q  <= writedata;
        A_SET:   data_q <= data_q | writedata[W-1:0];
        A_CLEAR: data_q <= data_q & ~writedata[W-1:0];
        default: ;
      endcase
    end
  end

  // A divider write restarts the blink cycle and takes priority over a terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wr && address == A_DIV) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (div_q == 32'd0) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == div_q - 32'd1) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA: readdata[W-1:0]          = data_q;
      A_MASK: readdata[NUM_DIGITS-1:0] = mask_q;
      A_DIV:  readdata                 = div_q;
      A_STAT: readdata[0]              = phase_q;
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign out_port[i*DIGIT_WIDTH +: DIGIT_WIDTH] =
      (mask_q[i] && phase_q) ? {DIGIT_WIDTH{1'b1}} : data_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
  end

endmodule

// File: tb/tb_qsys_hex_display_pio.sv
// Scoreboard bench for qsys_hex_display_pio: stimulus pushes predicted out_port/readdata,
// a negedge monitor pops and compares them.
module tb_qsys_hex_display_pio;

  localparam int ND = 4;
  localparam int DW = 7;
  localparam int W  = ND * DW;
  localparam logic [W-1:0] RSTV = {W{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  qsys_hex_display_pio #(
    .NUM_DIGITS(ND), .DIGIT_WIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [31:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: the blink phase is derived from clocks elapsed since the
  // last divider write (or reset), not from a modelled counter.
  logic [W-1:0]    m_data;
  logic [ND-1:0]   m_mask;
  logic [31:0]     m_div;
  longint unsigned m_elapsed;

  function automatic logic m_phase();
    if (m_div == 0) return 1'b0;
    return ((m_elapsed / m_div) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] m_out();
    logic [W-1:0] o;
    o = m_data;
    for (int i = 0; i < ND; i++)
      if (m_mask[i] && m_phase()) o[i*DW +: DW] = '1;
    return o;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {{(32-W){1'b0}}, m_data};
      3'd1:    return {{(32-ND){1'b0}}, m_mask};
      3'd2:    return m_div;
      3'd3:    return {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = RSTV; m_mask = '0; m_div = 32'd25_000_000; m_elapsed = 0;
  endtask

  // Monitor: compares whatever the stimulus predicted for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (out_port !== e.out || readdata !== e.rd) begin
        n_err++;
        $display("FAIL cycle_check t=%0t addr=%0d out_port=%h exp=%h readdata=%h exp=%h",
                 $time, address, out_port, e.out, readdata, e.rd);
      end
    end
  end

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Drive one bus cycle (called at posedge+1), predict, then advance the model on the edge.
  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    exp_t e;
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    e.out = reset_n ? m_out() : RSTV;
    e.rd  = m_read(a);
    exp_q.push_back(e);
    @(posedge clk);
    if (!reset_n) m_reset();
    else begin
      if (cs && !wn && a == 3'd2) begin
        m_div = wd; m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[W-1:0];
          3'd1: m_mask = wd[ND-1:0];
          3'd4: m_data = m_data | wd[W-1:0];
          3'd5: m_data = m_data & ~wd[W-1:0];
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) step(a, 1'b0, 1'b1, $urandom);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    m_reset();
    @(posedge clk); #1;
    rd(3'd0, 2);
    reset_n = 1'b1;
    check_now("reset_out", {4'd0, out_port}, 32'h0FFF_FFFF);
    rd(3'd0, 1); rd(3'd2, 1); rd(3'd3, 1); rd(3'd1, 1);

    // Plain, set and clear writes
    wr(3'd0, 32'hF123_4567); rd(3'd0, 1);
    wr(3'd4, 32'h0000_0080); rd(3'd0, 1);
    wr(3'd5, 32'h0000_0007); rd(3'd0, 1);
    check_now("set_clear", {4'd0, out_port}, 32'h0123_45E0);

    // Blink digit 1 with a 4-clock half-period
    wr(3'd0, 32'd0);
    wr(3'd1, 32'h2);
    wr(3'd2, 32'd4);
    rd(3'd3, 12);

    // Rewrite the divider on the terminal-count edge: no toggle
    wr(3'd2, 32'd4);
    rd(3'd3, 3);
    wr(3'd2, 32'd4);
    rd(3'd3, 9);

    // Divider zero holds phase low even with every digit masked
    wr(3'd0, 32'h0ABC_DEF1);
    wr(3'd1, 32'hF);
    wr(3'd2, 32'd0);
    rd(3'd3, 100);

    // Reserved addresses and read-only STATUS ignore writes
    wr(3'd7, 32'hFFFF_FFFF); wr(3'd6, 32'hFFFF_FFFF); wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd6, 1); rd(3'd7, 1); rd(3'd0, 1); rd(3'd1, 1); rd(3'd2, 1);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd2) ? $urandom_range(0, 6) : $urandom;
      step(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    // Asynchronous reset mid-blink
    wr(3'd0, 32'd0); wr(3'd1, 32'h1); wr(3'd2, 32'd4);
    rd(3'd3, 5);
    check_now("blink_phase_pre_reset", {4'd0, out_port}, 32'h0000_007F);
    #1 reset_n = 1'b0;
    #1 check_now("async_reset_out", {4'd0, out_port}, 32'h0FFF_FFFF);
    m_reset();
    rd(3'd6, 1); rd(3'd0, 1);
    reset_n = 1'b1;
    rd(3'd2, 1); rd(3'd3, 3);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/qsys_hex_display_pio.md
# qsys_hex_display_pio

Parametrised Avalon-MM output PIO driving N active-low seven-segment digits. It replaces the fixed 28-bit hex PIO in the Qsys system, keeping the same slave handshake. It adds atomic set/clear writes and a per-digit hardware blink engine with a programmable divider. Software writes segment patterns once, and blinking runs without CPU involvement.

## Interface
- NUM_DIGITS, 4, number of digits, 1..4.
- DIGIT_WIDTH, 7, segment bits per digit; NUM_DIGITS*DIGIT_WIDTH ≤ 32.
- RESET_VALUE, all ones (W bits), DATA reset value; all segments off.
- BLINK_DIV_RESET, 25000000, BLINK_DIV reset value, in clocks per half-period.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  combinational read data, zero-extended.
- out_port  out  W=NUM_DIGITS*DIGIT_WIDTH  segment outputs; digit i is bits [i*DIGIT_WIDTH +: DIGIT_WIDTH].

## Operation
Register map (word address):
- 0 DATA, RW, W bits: segment pattern.
- 1 BLINK_MASK, RW, NUM_DIGITS bits: bit i enables blinking on digit i.
- 2 BLINK_DIV, RW, 32 bits: half-period in clocks. 0 disables blinking.
- 3 STATUS, RO: bit0 = blink phase, bits[31:1] = 0. Writes are ignored.
- 4 SET, WO: DATA <= DATA | writedata[W-1:0]. Reads return 0.
- 5 CLEAR, WO: DATA <= DATA & ~writedata[W-1:0]. Reads return 0.
- 6, 7: reserved. Reads return 0; writes have no effect.

Blink engine:
- 32-bit counter cnt and 1-bit phase.
- When BLINK_DIV = N > 0: cnt increments each clock. When cnt == N-1, cnt <= 0 and phase toggles.
- When BLINK_DIV = 0: cnt and phase are held at 0.
- Any write to BLINK_DIV sets cnt <= 0 and phase <= 0 on the same edge, whatever the previous count.
- If BLINK_DIV is reduced below the current cnt, the clear-on-write rule applies, so no wrap-around past 2^32 can occur.

Output:
- Digit i of out_port = all ones (blank) when BLINK_MASK[i] && phase; otherwise DATA digit i.
- out_port is a pure mux of registers, so it is glitch-free at clock granularity.

Reset (reset_n low, asynchronous; takes effect mid-operation with no pending-write retention):
- DATA = RESET_VALUE, BLINK_MASK = 0, BLINK_DIV = BLINK_DIV_RESET, cnt = 0, phase = 0.
- Resulting out_port = RESET_VALUE and readdata = decode of current address.

## Timing
- Writes: zero wait states. Register update on the rising edge where the write is sampled.
- out_port reflects the new value immediately after that edge, i.e. 1-cycle write-to-output latency.
- Reads: zero wait states, zero read latency. readdata is combinational from address and registers; chipselect is not required for the decode.
- Phase toggles on the edge where cnt == N-1, so the first toggle comes N clocks after the BLINK_DIV write or reset release. The full blink period is 2N clocks.
- Simultaneous events:
  - A BLINK_DIV write on the same edge as a terminal count: the write wins (cnt = 0, phase = 0, no toggle).
  - A DATA/SET/CLEAR write during blank phase updates DATA; the change becomes visible when phase returns to 0 or the mask bit is cleared.
- Only one register is written per cycle (a single address), so SET and CLEAR never collide.

## Test plan
- Reset with NUM_DIGITS=4, then deassert -> out_port = 0x0FFFFFFF, read addr 0 = 0x0FFFFFFF, addr 2 = 25000000, addr 3 = 0.
- Write DATA=0x1234567, SET 0x0000080, CLEAR 0x0000007 -> out_port = 0x12345E0 one cycle after each write respectively, and readback matches.
- BLINK_DIV=4, BLINK_MASK=0x2, DATA=0 -> bits[13:7] = 0x7F during clocks 4..7 after the write, 0 during 0..3 and 8..11; other digits stay 0; STATUS bit0 tracks.
- BLINK_DIV=4, then rewrite BLINK_DIV=4 on the terminal-count edge -> no toggle; next toggle 4 clocks later.
- BLINK_DIV=0 with mask 0xF -> out_port = DATA steadily for 100 clocks; STATUS = 0.
- Assert reset_n mid-blink (phase=1) -> out_port = RESET_VALUE asynchronously, before the next edge; address 6 reads 0; writing 0xFFFFFFFF to address 7 leaves all registers unchanged.
